sensor_align: RTL
=================

SENSOR_ALIGN -- requirements
Module: sensor_align

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-002 SHALL have parameter TS_WIDTH, default 16, timestamp width (free-running, wraps).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, per-sensor buffer entries (power of two, >=2).
REQ-004 SHALL have parameter MAX_SKEW, default 8, max |imu_ts - lidar_ts| for a valid pair.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk, in, 1, rising-edge clock.
REQ-006 SHALL have rst_n, in, 1, asynchronous active-low reset.
REQ-007 SHALL have imu_valid in 1; imu_ready out 1; imu_data in DATA_WIDTH; imu_ts in TS_WIDTH.
REQ-008 SHALL have lidar_valid in 1; lidar_ready out 1; lidar_data in DATA_WIDTH; lidar_ts in TS_WIDTH.
REQ-009 SHALL have out_valid out 1; out_ready in 1; out_imu out DATA_WIDTH; out_lidar out DATA_WIDTH; out_ts out TS_WIDTH (later of the pair's two timestamps).

Function
REQ-010 SHALL accept a sample on a port when valid && ready at a rising edge, pushing {data, ts} into that sensor's FIFO.
REQ-011 SHALL drive imu_ready = !imu_fifo_full and lidar_ready = !lidar_fifo_full; no push-through-when-full bypass.
REQ-012 SHALL compute skew = (imu_head_ts - lidar_head_ts) mod 2^TS_WIDTH, interpreted as signed two's complement; wrap-around is handled by this rule alone.
REQ-013 SHALL make at most one decision per cycle, only when both FIFOs are non-empty and the output slot can load (empty, or out_valid && out_ready this cycle).
REQ-014 SHALL, when |skew| <= MAX_SKEW, pop both heads and load the output slot with {imu, lidar, max-by-skew ts}.
REQ-015 SHALL, when skew < -MAX_SKEW, pop and discard the IMU head only; when skew > MAX_SKEW, pop and discard the LiDAR head only; no output load in that cycle.
REQ-016 SHALL implement the output slot as a two-state FSM: EMPTY (out_valid=0) -> FULL on pair load; FULL -> EMPTY on out_ready with no new load; FULL -> FULL on out_ready with simultaneous load.
REQ-017 SHALL hold out_imu, out_lidar, out_ts stable while out_valid && !out_ready.
REQ-018 SHALL have latency of exactly one cycle: pair completed by the acceptance at edge N gives out_valid=1 after edge N+1 when the slot is free.
REQ-019 SHALL support simultaneous push and pop on the same FIFO in one cycle, occupancy unchanged.
REQ-020 SHALL sustain one pair per cycle with out_ready held high and both sensors streaming matched samples.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear both FIFO pointers/counts, output FSM to EMPTY, out_valid=0, out_imu/out_lidar/out_ts=0.
REQ-022 SHALL drive imu_ready=1 and lidar_ready=1 from the first cycle after rst_n deasserts.
REQ-023 SHALL discard all buffered and in-flight samples on reset mid-operation; no partial pair survives.

Configuration
REQ-024 SHALL, with SENSOR_ALIGN_STATS_EN defined, add outputs drop_imu_cnt and drop_lidar_cnt (16 bits each, reset 0), each incremented on every discard per REQ-015 and saturating at 16'hFFFF.
REQ-025 SHALL, without SENSOR_ALIGN_STATS_EN, have no counter ports or logic; alignment behaviour identical.

Structure
REQ-026 SHALL take DATA_WIDTH, TS_WIDTH, and a packed sample_t {data, ts} typedef from the shared fusion package, shared with the fusion core.
REQ-027 SHALL instantiate sub-module sensor_fifo (synchronous, parameterised on width/depth, full/empty flags) twice, once per sensor.

Verification
REQ-028 SHALL check: imu (100, ts=10) and lidar (120, ts=12), out_ready=1 -> one output {100,120,ts=12}, out_valid one cycle after the later acceptance.
REQ-029 SHALL check: imu ts=10, lidar ts=30, then imu ts=28 -> first IMU dropped (drop_imu_cnt=1 when enabled), pair {imu@28, lidar@30, ts=30}.
REQ-030 SHALL check wrap: imu ts=16'hFFFE, lidar ts=16'h0003 -> skew -5, paired, out_ts=16'h0003.
REQ-031 SHALL check back-pressure: out_ready=0 with 5 IMU and 5 LiDAR pushed -> imu_ready/lidar_ready fall after 4 buffered + 1 in slot; outputs stable; releasing out_ready drains 5 pairs in order.
REQ-032 SHALL check: rst_n pulsed low with both FIFOs at 3 entries and out_valid=1 -> out_valid=0 immediately, readies=1 after release, no stale pair emitted.
REQ-033 SHALL check streaming: 10 matched pairs (imu 100+i, lidar 120+2i, ts equal) with out_ready=1 -> 10 consecutive out_valid cycles, zero drops.

Source files
------------

// File: rtl/sensor_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_align_pkg
// Description : Shared fusion package. Holds the sample widths, the packed
//               {data, ts} sample type used by the aligner and the fusion
//               core, the output-slot state encoding and a saturating
//               increment helper for the optional drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_align_pkg;

   localparam int c_FUSION_DATA_WIDTH = 16;
   localparam int c_FUSION_TS_WIDTH   = 16;
   localparam logic [15:0] c_STAT_MAX = 16'hFFFF;

   typedef struct packed {
      logic [c_FUSION_DATA_WIDTH-1:0] data;
      logic [c_FUSION_TS_WIDTH-1:0]   ts;
   } sample_t;

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      if (value == c_STAT_MAX) begin
         return value;
      end
      return value + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_align_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sensor_fifo
// Description : Synchronous single-clock FIFO, one per sensor. The head entry
//               is visible combinationally on o_head while o_empty is low.
//               Push and pop may occur in the same cycle.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_push, i_data      - write strobe and entry (ignored if full)
//               i_pop               - remove head (ignored if empty)
//               o_head              - current head entry
//               o_full, o_empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == (c_AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // Storage is not reset: the head is only consumed while o_empty is low.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_AW+1)'(1);
            2'b01:   r_count <= r_count - (c_AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/sensor_align.sv
`default_nettype none
// ============================================================================
// Module      : sensor_align
// Description : Pairs IMU and LiDAR samples whose timestamps lie within
//               MAX_SKEW of each other. Each sensor is buffered in its own
//               FIFO; per cycle the two heads are compared with wrap-safe
//               signed arithmetic and either paired into the one-entry output
//               slot or the older head is discarded.
// Ports       : clk, rst_n                          - clock, async low reset
//               imu_valid/ready/data/ts             - IMU sample input
//               lidar_valid/ready/data/ts           - LiDAR sample input
//               out_valid/ready/imu/lidar/ts        - paired output
//               drop_imu_cnt, drop_lidar_cnt        - (SENSOR_ALIGN_STATS_EN)
//                                                     saturating discard counts
// Config      : define SENSOR_ALIGN_STATS_EN to add the discard counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_align
   import sensor_align_pkg::*;
#(
   parameter int DATA_WIDTH = c_FUSION_DATA_WIDTH,
   parameter int TS_WIDTH   = c_FUSION_TS_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_SKEW   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  imu_valid,
   output logic                  imu_ready,
   input  logic [DATA_WIDTH-1:0] imu_data,
   input  logic [TS_WIDTH-1:0]   imu_ts,
   input  logic                  lidar_valid,
   output logic                  lidar_ready,
   input  logic [DATA_WIDTH-1:0] lidar_data,
   input  logic [TS_WIDTH-1:0]   lidar_ts,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_imu,
   output logic [DATA_WIDTH-1:0] out_lidar,
   output logic [TS_WIDTH-1:0]   out_ts
`ifdef SENSOR_ALIGN_STATS_EN
   ,
   output logic [15:0]           drop_imu_cnt,
   output logic [15:0]           drop_lidar_cnt
`endif
);

   localparam logic signed [TS_WIDTH:0] c_SKEW_HI = (TS_WIDTH+1)'(MAX_SKEW);
   localparam logic signed [TS_WIDTH:0] c_SKEW_LO = -c_SKEW_HI;

   sample_t               w_imu_in;
   sample_t               w_lidar_in;
   sample_t               w_imu_head;
   sample_t               w_lidar_head;
   logic                  w_imu_full;
   logic                  w_imu_empty;
   logic                  w_lidar_full;
   logic                  w_lidar_empty;
   logic                  w_imu_pop;
   logic                  w_lidar_pop;
   logic [TS_WIDTH-1:0]   w_ts_diff;
   logic signed [TS_WIDTH:0] w_skew;
   logic                  w_drop_imu;
   logic                  w_drop_lidar;
   logic                  w_can_load;
   logic                  w_decide;
   logic                  w_load;
   logic [TS_WIDTH-1:0]   w_pair_ts;
   slot_state_t           r_state;
   slot_state_t           w_state_nxt;
   logic [DATA_WIDTH-1:0] r_out_imu;
   logic [DATA_WIDTH-1:0] r_out_lidar;
   logic [TS_WIDTH-1:0]   r_out_ts;

   assign w_imu_in   = '{data: imu_data,   ts: imu_ts};
   assign w_lidar_in = '{data: lidar_data, ts: lidar_ts};

   sensor_fifo #(
      .WIDTH ($bits(sample_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_imu_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (imu_valid),
      .i_data  (w_imu_in),
      .i_pop   (w_imu_pop),
      .o_head  (w_imu_head),
      .o_full  (w_imu_full),
      .o_empty (w_imu_empty)
   );

   sensor_fifo #(
      .WIDTH ($bits(sample_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_lidar_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (lidar_valid),
      .i_data  (w_lidar_in),
      .i_pop   (w_lidar_pop),
      .o_head  (w_lidar_head),
      .o_full  (w_lidar_full),
      .o_empty (w_lidar_empty)
   );

   assign imu_ready   = !w_imu_full;
   assign lidar_ready = !w_lidar_full;

   // Modular difference read as two's complement; sign-extending by one bit
   // lets the window test use ordinary signed compares without overflow.
   assign w_ts_diff    = w_imu_head.ts - w_lidar_head.ts;
   assign w_skew       = signed'({w_ts_diff[TS_WIDTH-1], w_ts_diff});
   assign w_drop_imu   = (w_skew < c_SKEW_LO);
   assign w_drop_lidar = (w_skew > c_SKEW_HI);

   assign w_can_load  = (r_state == SLOT_EMPTY) || out_ready;
   assign w_decide    = !w_imu_empty && !w_lidar_empty && w_can_load;
   assign w_load      = w_decide && !w_drop_imu && !w_drop_lidar;
   // A head is popped when it is paired or when it is the stale one.
   assign w_imu_pop   = w_decide && !w_drop_lidar;
   assign w_lidar_pop = w_decide && !w_drop_imu;
   // Negative skew means the LiDAR stamp is the later one.
   assign w_pair_ts   = w_skew[TS_WIDTH] ? w_lidar_head.ts : w_imu_head.ts;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SLOT_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SLOT_EMPTY: if (w_load) w_state_nxt = SLOT_FULL;
         SLOT_FULL:  if (out_ready && !w_load) w_state_nxt = SLOT_EMPTY;
         default:    w_state_nxt = SLOT_EMPTY;
      endcase
   end

   // Slot payload only changes on a load, so it holds under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_imu   <= '0;
         r_out_lidar <= '0;
         r_out_ts    <= '0;
      end else if (w_load) begin
         r_out_imu   <= w_imu_head.data;
         r_out_lidar <= w_lidar_head.data;
         r_out_ts    <= w_pair_ts;
      end
   end

   assign out_valid = (r_state == SLOT_FULL);
   assign out_imu   = r_out_imu;
   assign out_lidar = r_out_lidar;
   assign out_ts    = r_out_ts;

`ifdef SENSOR_ALIGN_STATS_EN
   logic [15:0] r_drop_imu_cnt;
   logic [15:0] r_drop_lidar_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_imu_cnt   <= '0;
         r_drop_lidar_cnt <= '0;
      end else begin
         if (w_decide && w_drop_imu) begin
            r_drop_imu_cnt <= sat_inc(r_drop_imu_cnt);
         end
         if (w_decide && w_drop_lidar) begin
            r_drop_lidar_cnt <= sat_inc(r_drop_lidar_cnt);
         end
      end
   end

   assign drop_imu_cnt   = r_drop_imu_cnt;
   assign drop_lidar_cnt = r_drop_lidar_cnt;
`endif

endmodule
`default_nettype wire
